adder: RTL and testbench

Registered 32-bit adder for the RISC-V datapath. It produces either `in1 + 4` for PC increment or `in1 + in2` for branch/jump targets, selected by `sel`. The result is registered on the rising clock edge together with carry, overflow and zero status flags. It sits in the fetch/PC-update path next to the PC register.

---
 rtl/adder.sv | 70 +++++++
 tb/tb_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered WIDTH-bit adder for PC update: out = in1 + (sel ? INC : in2), one-cycle latency.
// Define ADDER_FLAGS_EN to build the carry/overflow/zero flag registers; otherwise the flags read 0.
module adder #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] out_d, out_q;

    // A known sel selects the constant outright, so an X on in2 cannot leak through.
    assign op_b = sel ? INC_W : in2;

`ifdef ADDER_FLAGS_EN
    logic [WIDTH:0] sum;
    logic           carry_d, carry_q;
    logic           ovf_d, ovf_q;
    logic           zero_d, zero_q;

    assign sum     = {1'b0, in1} + {1'b0, op_b};
    assign out_d   = sum[WIDTH-1:0];
    assign carry_d = sum[WIDTH];
    assign ovf_d   = (in1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    assign zero_d  = (sum[WIDTH-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en) begin
            out_q   <= out_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign out_d = in1 + op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     out_q <= '0;
        else if (en) out_q <= out_d;
    end

    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign out = out_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: table-driven vectors through a scoreboard queue, plus reset and random sequences.
module tb_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [31:0] out;
    logic        carry, overflow, zero;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [31:0] out;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic        en;
        logic        sel;
        logic [31:0] in1;
        logic [31:0] in2;
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];
    exp_t last;

    adder #(.WIDTH(32), .INC(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in1(in1), .in2(in2), .sel(sel),
        .out(out), .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t mask(exp_t e);
        exp_t r = e;
`ifndef ADDER_FLAGS_EN
        r.c = 1'b0;
        r.v = 1'b0;
        r.z = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic chk_all(string name, exp_t e);
        chk({name, ".out"}, out, e.out);
        chk({name, ".carry"}, 32'(carry), 32'(e.c));
        chk({name, ".overflow"}, 32'(overflow), 32'(e.v));
        chk({name, ".zero"}, 32'(zero), 32'(e.z));
    endtask

    // Drive after a falling edge, push expectation, compare at the next falling edge.
    task automatic step(string name, vec_t v);
        exp_t e;
        en  = v.en;
        sel = v.sel;
        in1 = v.in1;
        in2 = v.in2;
        exp_q.push_back(mask(v.e));
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            chk_all(name, e);
            last = e;
        end
    endtask

    vec_t vt[$];

    initial begin
        vec_t v;
        logic [32:0] s;
        // {en, sel, in1, in2, {out, carry, overflow, zero}}
        vt.push_back('{1'b1, 1'b1, 32'd10,        32'hxxxxxxxx, '{32'd14,        1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b1, 1'b0, 32'd20,        32'd30,       '{32'd50,        1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b0, 1'b0, 32'd1,         32'd30,       '{32'd50,        1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b1, 1'b1, 32'hFFFFFFFC,  32'hxxxxxxxx, '{32'd0,         1'b1, 1'b0, 1'b1}});
        vt.push_back('{1'b0, 1'b0, 32'd7,         32'd7,        '{32'd0,         1'b1, 1'b0, 1'b1}});
        vt.push_back('{1'b1, 1'b0, 32'h7FFFFFFF,  32'd1,        '{32'h80000000,  1'b0, 1'b1, 1'b0}});
        vt.push_back('{1'b1, 1'b1, 32'h7FFFFFFC,  32'hFFFFFFFF, '{32'h80000000,  1'b0, 1'b1, 1'b0}});
        vt.push_back('{1'b1, 1'b1, 32'h7FFFFFFB,  32'h0,        '{32'h7FFFFFFF,  1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b1, 1'b0, 32'hFFFFFFFF,  32'd1,        '{32'd0,         1'b1, 1'b0, 1'b1}});
        vt.push_back('{1'b1, 1'b0, 32'h80000000,  32'h80000000, '{32'd0,         1'b1, 1'b1, 1'b1}});
        vt.push_back('{1'b1, 1'b0, 32'd0,         32'd0,        '{32'd0,         1'b0, 1'b0, 1'b1}});
        vt.push_back('{1'b1, 1'b1, 32'd100,       32'd8,        '{32'd104,       1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b1, 1'b0, 32'd100,       32'd8,        '{32'd108,       1'b0, 1'b0, 1'b0}});
        vt.push_back('{1'b1, 1'b1, 32'd100,       32'd8,        '{32'd104,       1'b0, 1'b0, 1'b0}});

        // Asynchronous reset from power-up, checked before any clock edge.
        #2 rst = 1'b1;
        #1 chk_all("reset_async", '{32'd0, 1'b0, 1'b0, 1'b0});
        en = 1'b1; sel = 1'b1; in1 = 32'd40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset_holds", '{32'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        en  = 1'b0;

        for (int i = 0; i < vt.size(); i++) step($sformatf("vec%0d", i), vt[i]);

        // Mid-cycle reset while out = 50 clears without a clock edge.
        step("load50", '{1'b1, 1'b0, 32'd20, 32'd30, '{32'd50, 1'b0, 1'b0, 1'b0}});
        #2 rst = 1'b1;
        #1 chk_all("reset_mid", '{32'd0, 1'b0, 1'b0, 1'b0});
        en = 1'b1; sel = 1'b1; in1 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        chk_all("reset_prio", '{32'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        step("post_reset", '{1'b1, 1'b1, 32'hFFFFFFFC, 32'hxxxxxxxx, '{32'd0, 1'b1, 1'b0, 1'b1}});

        // Random back-to-back traffic against a reference sum.
        for (int i = 0; i < 40; i++) begin
            v.en  = ($urandom_range(0, 3) != 0);
            v.sel = $urandom_range(0, 1) == 1;
            v.in1 = (i % 5 == 0) ? 32'h7FFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            v.in2 = $urandom;
            if (v.en) begin
                s = {1'b0, v.in1} + (v.sel ? 33'd4 : {1'b0, v.in2});
                v.e.out = s[31:0];
                v.e.c   = s[32];
                v.e.v   = v.sel ? (v.in1[31] == 1'b0 && s[31] == 1'b1)
                                : (v.in1[31] == v.in2[31] && s[31] != v.in1[31]);
                v.e.z   = (s[31:0] == 32'd0);
            end else begin
                v.e = last;
            end
            step($sformatf("rand%0d", i), v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
